axis_monitor: RTL and testbench

//  Passive monitor on one AXI stream link (data/valid/ready); never drives the link.

---
 rtl/axis_monitor.sv | 151 +++++++++++++++
 tb/tb_axis_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_monitor.sv
// ---------------------------------------------------------------------------
// axis_monitor
//   Passive observer of one AXI-stream link (data/valid/ready).
//   - count : handshaken beats since reset/clear, wraps
//   - stalls: cycles with valid && !ready, saturates at all-ones
//   - sdata : every period-th beat is captured; saved pulses on capture
//   Optional producer protocol checker, enabled by the macro
//   AXIS_MONITOR_CHECK_EN:
//     a stalled beat must stay valid with stable data on the next cycle.
//   Handshake: a beat is transferred on a rising clock edge where
//   valid && ready are both high; the monitor only samples these signals.
// ---------------------------------------------------------------------------
module axis_monitor #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   clear,
   input  logic [DATA_WIDTH-1:0]  data,
   input  logic                   valid,
   input  logic                   ready,
   input  logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [COUNT_WIDTH-1:0] stalls,
   output logic [DATA_WIDTH-1:0]  sdata,
   output logic                   saved,
   output logic                   error,
   output logic [1:0]             error_code
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic                   beat;
   logic                   stall;
   logic                   sample_en;
   logic                   capture;

   logic [COUNT_WIDTH-1:0] count_q,  count_d;
   logic [COUNT_WIDTH-1:0] stalls_q, stalls_d;
   logic [COUNT_WIDTH-1:0] phase_q,  phase_d;
   logic [DATA_WIDTH-1:0]  sdata_q,  sdata_d;
   logic                   saved_q,  saved_d;

   assign beat      = valid & ready;
   assign stall     = valid & ~ready;
   assign sample_en = beat & (period != CNT_ZERO);
   // ">=" rather than "==" so that lowering period mid-run captures on the
   // next beat instead of letting the phase wrap all the way around.
   assign capture   = sample_en & (phase_q >= (period - CNT_ONE));

   // Next-state for counters, phase and sample register; clear dominates.
   always_comb begin
      count_d  = count_q;
      stalls_d = stalls_q;
      phase_d  = phase_q;
      sdata_d  = sdata_q;
      saved_d  = 1'b0;
      if (clear) begin
         count_d  = CNT_ZERO;
         stalls_d = CNT_ZERO;
         phase_d  = CNT_ZERO;
      end else begin
         if (beat) begin
            count_d = count_q + CNT_ONE;
         end
         if (stall && (stalls_q != CNT_MAX)) begin
            stalls_d = stalls_q + CNT_ONE;
         end
         if (capture) begin
            sdata_d = data;
            saved_d = 1'b1;
            phase_d = CNT_ZERO;
         end else if (sample_en) begin
            phase_d = phase_q + CNT_ONE;
         end
      end
   end

   // Counter, phase and sample registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_q  <= CNT_ZERO;
         stalls_q <= CNT_ZERO;
         phase_q  <= CNT_ZERO;
         sdata_q  <= '0;
         saved_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         stalls_q <= stalls_d;
         phase_q  <= phase_d;
         sdata_q  <= sdata_d;
         saved_q  <= saved_d;
      end
   end

   assign count  = count_q;
   assign stalls = stalls_q;
   assign sdata  = sdata_q;
   assign saved  = saved_q;

`ifdef AXIS_MONITOR_CHECK_EN
   logic                  pend_q,  pend_d;
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  error_q, error_d;
   logic [1:0]            code_q,  code_d;
   logic                  viol_drop;
   logic                  viol_data;

   // A stall last cycle obliges the producer to hold valid and data now.
   assign viol_drop = pend_q & ~valid;
   assign viol_data = pend_q & valid & (data != pdata_q);

   // Checker next-state: sticky flags, clear drops any same-cycle violation.
   always_comb begin
      pend_d  = stall;
      pdata_d = stall ? data : pdata_q;
      error_d = error_q | viol_drop | viol_data;
      code_d  = code_q | {viol_data, viol_drop};
      if (clear) begin
         pend_d  = 1'b0;
         error_d = 1'b0;
         code_d  = 2'b00;
      end
   end

   // Checker registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pend_q  <= 1'b0;
         pdata_q <= '0;
         error_q <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         pend_q  <= pend_d;
         pdata_q <= pdata_d;
         error_q <= error_d;
         code_q  <= code_d;
      end
   end

   assign error      = error_q;
   assign error_code = code_q;
`else
   assign error      = 1'b0;
   assign error_code = 2'b00;
`endif

endmodule

// File: tb/tb_axis_monitor.sv
// ---------------------------------------------------------------------------
// tb_axis_monitor
//   Table-driven vectors, hand-written corner sequences and a randomized run
//   against a behavioural model of the monitor. Build with
//   AXIS_MONITOR_CHECK_EN defined to exercise the protocol checker.
// ---------------------------------------------------------------------------
module tb_axis_monitor;

`ifdef AXIS_MONITOR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clock;
   logic       resetn;
   logic       clear;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic [7:0] period;
   logic [7:0] count;
   logic [7:0] stalls;
   logic [7:0] sdata;
   logic       saved;
   logic       error;
   logic [1:0] error_code;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int m_count, m_stalls, m_since, m_sdata, m_saved, m_err0, m_err1, m_pend, m_pdata;

   axis_monitor #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
      .clock(clock), .resetn(resetn), .clear(clear), .data(data),
      .valid(valid), .ready(ready), .period(period), .count(count),
      .stalls(stalls), .sdata(sdata), .saved(saved), .error(error),
      .error_code(error_code)
   );

   // clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count = 0; m_stalls = 0; m_since = 0; m_sdata = 0; m_saved = 0;
      m_err0 = 0; m_err1 = 0; m_pend = 0; m_pdata = 0;
   endtask

   // One clock of the monitor written from its rules.
   task automatic model_step(input bit c, input int d, input bit v, input bit r, input int p);
      m_saved = 0;
      if (c) begin
         m_count = 0; m_stalls = 0; m_since = 0;
         m_err0 = 0; m_err1 = 0; m_pend = 0;
         return;
      end
      if (v && r) begin
         m_count = (m_count + 1) % 256;
         if (p != 0) begin
            if (m_since + 1 >= p) begin
               m_sdata = d; m_saved = 1; m_since = 0;
            end else begin
               m_since = m_since + 1;
            end
         end
      end
      if (v && !r && m_stalls < 255) m_stalls = m_stalls + 1;
      if (CHK) begin
         if (m_pend != 0 && !v) m_err0 = 1;
         if (m_pend != 0 && v && d != m_pdata) m_err1 = 1;
         m_pend = (v && !r) ? 1 : 0;
         if (v && !r) m_pdata = d;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".count"},  int'(count),  m_count);
      check({tag, ".stalls"}, int'(stalls), m_stalls);
      check({tag, ".sdata"},  int'(sdata),  m_sdata);
      check({tag, ".saved"},  int'(saved),  m_saved);
      check({tag, ".error"},  int'(error),  (m_err0 | m_err1));
      check({tag, ".code"},   int'(error_code), m_err1 * 2 + m_err0);
   endtask

   // Drive one cycle, advance the model with the same inputs.
   task automatic step(input bit c, input int d, input bit v, input bit r, input int p);
      clear = c; data = 8'(d); valid = v; ready = r; period = 8'(p);
      @(posedge clock);
      #1;
      model_step(c, d, v, r, p);
   endtask

   task automatic do_reset();
      clear = 0; data = 0; valid = 0; ready = 0; period = 0;
      resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   typedef struct {
      bit clr; int d; bit v; bit r; int p;
      int e_count; int e_stalls; int e_sdata; int e_saved;
   } vec_t;
   vec_t vecs[10];

   initial begin
      //           clr d  v  r  p   count stalls sdata saved
      vecs[0] = '{0, 1, 1, 1, 2,   1, 0, 0, 0};
      vecs[1] = '{0, 2, 1, 1, 2,   2, 0, 2, 1};
      vecs[2] = '{0, 3, 1, 1, 2,   3, 0, 2, 0};
      vecs[3] = '{0, 4, 1, 1, 2,   4, 0, 4, 1};
      vecs[4] = '{0, 5, 1, 1, 2,   5, 0, 4, 0};
      vecs[5] = '{0, 5, 1, 0, 2,   5, 1, 4, 0};
      vecs[6] = '{0, 5, 1, 1, 2,   6, 1, 5, 1};
      vecs[7] = '{0, 0, 0, 0, 2,   6, 1, 5, 0};
      vecs[8] = '{1, 9, 1, 1, 2,   0, 0, 5, 0};
      vecs[9] = '{0, 7, 1, 1, 2,   1, 0, 5, 0};

      resetn = 1'b1;
      do_reset();
      check_model("reset");

      // --- table: period 2 sampling, stall, clear beating a beat
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].clr, vecs[i].d, vecs[i].v, vecs[i].r, vecs[i].p);
         check($sformatf("vec%0d.count", i),  int'(count),  vecs[i].e_count);
         check($sformatf("vec%0d.stalls", i), int'(stalls), vecs[i].e_stalls);
         check($sformatf("vec%0d.sdata", i),  int'(sdata),  vecs[i].e_sdata);
         check($sformatf("vec%0d.saved", i),  int'(saved),  vecs[i].e_saved);
         check($sformatf("vec%0d.error", i),  int'(error),  0);
      end

      // --- stall saturation
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         step(0, 8'h3c, 1, 0, 1);
         if (i == 200) check("stall200", int'(stalls), 200);
         if (i == 255) check("stall255", int'(stalls), 255);
         if (i == 256) check("stall_hold256", int'(stalls), 255);
      end
      check("stall_hold300", int'(stalls), 255);
      check("stall_count", int'(count), 0);
      check("stall_err", int'(error), 0);

      // --- period 0: no sampling
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(0, i + 17, 1, 1, 0);
         check($sformatf("p0_saved%0d", i), int'(saved), 0);
      end
      check("p0_count", int'(count), 10);
      check("p0_sdata", int'(sdata), 0);

      // --- lowering period mid-run
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         step(0, 8'h40 + i, 1, 1, 5);
         check($sformatf("p5_saved%0d", i), int'(saved), (i == 5) ? 1 : 0);
      end
      check("p5_sdata", int'(sdata), 8'h45);
      step(0, 8'h77, 1, 1, 2);
      check("lower_saved", int'(saved), 1);
      check("lower_sdata", int'(sdata), 8'h77);
      step(0, 8'h78, 1, 1, 2);
      check("lower_phase0", int'(saved), 0);
      step(0, 8'h79, 1, 1, 2);
      check("lower_next", int'(saved), 1);
      check("lower_sdata2", int'(sdata), 8'h79);
      check_model("lower");

      // --- protocol checker
      do_reset();
      step(0, 8'hA5, 1, 0, 0);
      check("chk_pend_err", int'(error), 0);
      step(0, 8'hA5, 0, 0, 0);
      check("chk_drop_err", int'(error), CHK ? 1 : 0);
      check("chk_drop_code", int'(error_code), CHK ? 1 : 0);
      step(0, 8'h11, 1, 0, 0);
      check("chk_sticky_code", int'(error_code), CHK ? 1 : 0);
      step(0, 8'h22, 1, 0, 0);
      check("chk_data_code", int'(error_code), CHK ? 3 : 0);
      check("chk_data_err", int'(error), CHK ? 1 : 0);
      step(1, 8'h22, 0, 0, 0);
      check("chk_clr_err", int'(error), 0);
      check("chk_clr_code", int'(error_code), 0);
      check("chk_clr_count", int'(count), 0);
      check("chk_clr_stalls", int'(stalls), 0);
      // violation in a clear cycle is dropped
      step(0, 8'h30, 1, 0, 0);
      step(1, 8'h31, 0, 0, 0);
      step(0, 8'h31, 0, 0, 0);
      check("chk_clr_drop", int'(error), 0);

      // --- beat and clear together, then async reset mid-stream
      do_reset();
      step(0, 8'h01, 1, 1, 1);
      step(1, 8'h02, 1, 1, 1);
      check("clr_beat_count", int'(count), 0);
      check("clr_beat_saved", int'(saved), 0);
      check("clr_beat_sdata", int'(sdata), 1);
      step(0, 8'h03, 1, 0, 1);
      step(0, 8'h04, 1, 1, 1);
      clear = 0; data = 8'h05; valid = 1; ready = 0; period = 1;
      @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      check("areset.count", int'(count), 0);
      check("areset.stalls", int'(stalls), 0);
      check("areset.sdata", int'(sdata), 0);
      check("areset.saved", int'(saved), 0);
      check("areset.error", int'(error), 0);
      check("areset.code", int'(error_code), 0);
      model_reset();
      @(negedge clock);
      resetn = 1'b1;

      // --- randomized run against the model
      begin
         int p, d;
         bit v, pv;
         p = 3; d = 0; pv = 0;
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) p = $urandom_range(0, 4);
            // producer is mostly well-behaved while stalled
            if (!pv || $urandom_range(0, 15) == 0) d = $urandom_range(0, 255);
            v = ($urandom_range(0, 9) < 7);
            if (pv && $urandom_range(0, 15) != 0) v = 1'b1;
            step(($urandom_range(0, 49) == 0), d, v, ($urandom_range(0, 9) < 6), p);
            pv = valid & ~ready;
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
